// File: rtl/banked_memory_pkg.sv
// -----------------------------------------------------------------------------
// banked_memory_pkg
// Shared definitions for the CPU6 system-memory block: transfer FSM encoding,
// fixed register addresses, constant read values and small parity/decode
// helper functions.
// -----------------------------------------------------------------------------
package banked_memory_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2
    } state_e;

    localparam logic [15:0] ADDR_VEC      = 16'hfd00;
    localparam logic [15:0] ADDR_MUX_STAT = 16'hf200;
    localparam logic [15:0] ADDR_MUX_DATA = 16'hf201;
    localparam logic [15:0] ADDR_DIP      = 16'hf110;
    localparam logic [15:0] ADDR_SIM_END  = 16'hf900;

    localparam logic [7:0] JMP_OPCODE     = 8'h71;
    localparam logic [7:0] TX_READY_STAT  = 8'h02;
    localparam logic [7:0] SIM_END_KEY    = 8'h01;
    localparam logic [7:0] UART_DATA_MASK = 8'h7f;

    // Even parity over one data byte.
    function automatic logic even_parity(input logic [7:0] data);
        return ^data;
    endfunction

    // True when addr lies in the 2**aw window starting at base.
    function automatic logic in_window(input logic [15:0] addr, input logic [15:0] base, input int aw);
        return (addr >> aw) == (base >> aw);
    endfunction

endpackage

// File: rtl/banked_memory_if.sv
// -----------------------------------------------------------------------------
// banked_memory_if
// CPU6 memory bus. The master holds address/enables/data_in until ready;
// the slave returns data_out, a one-cycle ready strobe and bus_err.
//   master: drives address, read_en, write_en, data_in
//   slave : drives data_out, ready, bus_err
// -----------------------------------------------------------------------------
interface banked_memory_if;
    logic [15:0] address;
    logic        read_en;
    logic        write_en;
    logic [7:0]  data_in;
    logic [7:0]  data_out;
    logic        ready;
    logic        bus_err;

    modport master (
        output address, read_en, write_en, data_in,
        input  data_out, ready, bus_err
    );

    modport slave (
        input  address, read_en, write_en, data_in,
        output data_out, ready, bus_err
    );
endinterface

// File: rtl/banked_memory_memory_array.sv
// -----------------------------------------------------------------------------
// memory_array
// Storage array with synchronous write and asynchronous read.
//   clock  in  write clock
//   we     in  write enable
//   waddr  in  write index (AW bits)
//   wdata  in  write data (DW bits)
//   raddr  in  read index (AW bits)
//   rdata  out read data, combinational from raddr
// -----------------------------------------------------------------------------
module memory_array #(
    parameter int AW = 11,
    parameter int DW = 8
) (
    input  logic          clock,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem_r [0:(2**AW)-1];

    // Write port: one cell per clock when enabled.
    always_ff @(posedge clock) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/banked_memory.sv
// -----------------------------------------------------------------------------
// banked_memory
// CPU6 system memory: ROM and RAM windows, reset vector (JMP VEC_TARGET at
// FD00..FD02), DIP/UART-stub/sim-end registers, with a ready handshake and
// WAIT_STATES programmable wait cycles (IDLE -> WAIT -> ACK -> IDLE).
// Ports:
//   clock, reset                 system clock, async active-high reset
//   bus (banked_memory_if.slave) address/read_en/write_en/data_in in,
//                                data_out/ready/bus_err out
//   uart_tx_valid, uart_tx_data  strobe + 7-bit data of a write to F201
//   sim_end                      sticky, set by writing 8'h01 to F900
//   parity_inject, parity_err    RAM parity fault injection / sticky error
// Optional feature: define MEM_PARITY_EN for 9-bit RAM cells with parity.
// -----------------------------------------------------------------------------
module banked_memory
    import banked_memory_pkg::*;
#(
    parameter logic [15:0] ROM_BASE    = 16'h8000,
    parameter int          ROM_AW      = 11,
    parameter logic [15:0] RAM_BASE    = 16'hb800,
    parameter int          RAM_AW      = 11,
    parameter int          WAIT_STATES = 0,
    parameter logic [15:0] VEC_TARGET  = 16'h8001,
    parameter logic [7:0]  DIP_VALUE   = 8'h0d
) (
    input  logic                 clock,
    input  logic                 reset,
    banked_memory_if.slave       bus,
    output logic                 uart_tx_valid,
    output logic [7:0]           uart_tx_data,
    output logic                 sim_end,
    input  logic                 parity_inject,
    output logic                 parity_err
);

    localparam bit         HAS_WAIT  = (WAIT_STATES > 0);
    localparam logic [3:0] WAIT_LOAD = HAS_WAIT ? 4'(WAIT_STATES - 1) : 4'd0;
`ifdef MEM_PARITY_EN
    localparam int RAM_DW = 9;
`else
    localparam int RAM_DW = 8;
`endif

    state_e            state_r, state_nx_s;
    logic [3:0]        wait_cnt_r;
    logic [15:0]       addr_r;
    logic [7:0]        wdata_r;
    logic              is_wr_r, both_r, inject_r;
    logic [15:0]       cur_addr_s;
    logic [7:0]        cur_data_s;
    logic              cur_wr_s, cur_both_s;
    logic              req_s, load_s, ack_nx_s, commit_s;
    logic              vec_hit_s, rom_hit_s, ram_hit_s;
    logic [7:0]        rom_rdata_s, rd_data_s;
    logic [RAM_DW-1:0] ram_rdata_s, ram_wdata_s;
    logic              ram_we_s, par_bad_s, bus_err_s;
    logic [7:0]        data_out_r, uart_tx_data_r;
    logic              ready_r, bus_err_r, uart_tx_valid_r, sim_end_r, parity_err_r;

    assign req_s = bus.read_en | bus.write_en;

    // FSM state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (req_s) begin
                    state_nx_s = HAS_WAIT ? ST_WAIT : ST_ACK;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (wait_cnt_r == 4'd0) begin
                    state_nx_s = ST_ACK;
                end else begin
                    state_nx_s = ST_WAIT;
                end
            end
            ST_ACK:  state_nx_s = ST_IDLE;
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // FSM outputs: latch request, ACK about to start, commit of the write.
    always_comb begin
        load_s   = 1'b0;
        ack_nx_s = 1'b0;
        commit_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                load_s   = req_s;
                ack_nx_s = req_s && !HAS_WAIT;
            end
            ST_WAIT: ack_nx_s = (wait_cnt_r == 4'd0);
            ST_ACK:  commit_s = is_wr_r;
            default: begin
                load_s   = 1'b0;
                ack_nx_s = 1'b0;
                commit_s = 1'b0;
            end
        endcase
    end

    // Wait-state down counter, loaded as the request is accepted.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wait_cnt_r <= 4'd0;
        end else if (load_s) begin
            wait_cnt_r <= WAIT_LOAD;
        end else if ((state_r == ST_WAIT) && (wait_cnt_r != 4'd0)) begin
            wait_cnt_r <= wait_cnt_r - 4'd1;
        end else begin
            wait_cnt_r <= wait_cnt_r;
        end
    end

    // Request capture; both enables high is handled as a write.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            addr_r   <= 16'h0000;
            wdata_r  <= 8'h00;
            is_wr_r  <= 1'b0;
            both_r   <= 1'b0;
            inject_r <= 1'b0;
        end else if (load_s) begin
            addr_r   <= bus.address;
            wdata_r  <= bus.data_in;
            is_wr_r  <= bus.write_en;
            both_r   <= bus.read_en & bus.write_en;
            inject_r <= parity_inject;
        end else begin
            addr_r   <= addr_r;
            wdata_r  <= wdata_r;
            is_wr_r  <= is_wr_r;
            both_r   <= both_r;
            inject_r <= inject_r;
        end
    end

    // The transfer being decoded: live bus in IDLE (zero-wait path), latched copy after.
    always_comb begin
        if (state_r == ST_IDLE) begin
            cur_addr_s = bus.address;
            cur_data_s = bus.data_in;
            cur_wr_s   = bus.write_en;
            cur_both_s = bus.read_en & bus.write_en;
        end else begin
            cur_addr_s = addr_r;
            cur_data_s = wdata_r;
            cur_wr_s   = is_wr_r;
            cur_both_s = both_r;
        end
    end

    assign vec_hit_s = (cur_addr_s[15:2] == ADDR_VEC[15:2]) && (cur_addr_s[1:0] != 2'b11);
    assign rom_hit_s = in_window(cur_addr_s, ROM_BASE, ROM_AW);
    assign ram_hit_s = in_window(cur_addr_s, RAM_BASE, RAM_AW);
    assign bus_err_s = cur_both_s | (cur_wr_s & (rom_hit_s | vec_hit_s));
    assign ram_we_s  = commit_s & ram_hit_s;

    // Read map in priority order.
    always_comb begin
        rd_data_s = 8'h00;
        if (vec_hit_s) begin
            case (cur_addr_s[1:0])
                2'd0:    rd_data_s = JMP_OPCODE;
                2'd1:    rd_data_s = VEC_TARGET[15:8];
                2'd2:    rd_data_s = VEC_TARGET[7:0];
                default: rd_data_s = 8'h00;
            endcase
        end else if (cur_addr_s == ADDR_MUX_STAT) begin
            rd_data_s = TX_READY_STAT;
        end else if (cur_addr_s == ADDR_DIP) begin
            rd_data_s = DIP_VALUE;
        end else if (rom_hit_s) begin
            rd_data_s = rom_rdata_s;
        end else if (ram_hit_s) begin
            rd_data_s = ram_rdata_s[7:0];
        end else begin
            rd_data_s = 8'h00;
        end
    end

`ifdef MEM_PARITY_EN
    assign ram_wdata_s = {even_parity(wdata_r) ^ inject_r, wdata_r};
    assign par_bad_s   = ram_rdata_s[8] != even_parity(ram_rdata_s[7:0]);
`else
    logic unused_inject_s;
    assign unused_inject_s = inject_r;
    assign ram_wdata_s     = wdata_r;
    assign par_bad_s       = 1'b0;
`endif

    memory_array #(.AW(ROM_AW), .DW(8)) u_rom (
        .clock (clock),
        .we    (1'b0),
        .waddr ({ROM_AW{1'b0}}),
        .wdata (8'h00),
        .raddr (cur_addr_s[ROM_AW-1:0]),
        .rdata (rom_rdata_s)
    );

    memory_array #(.AW(RAM_AW), .DW(RAM_DW)) u_ram (
        .clock (clock),
        .we    (ram_we_s),
        .waddr (addr_r[RAM_AW-1:0]),
        .wdata (ram_wdata_s),
        .raddr (cur_addr_s[RAM_AW-1:0]),
        .rdata (ram_rdata_s)
    );

    // Registered outputs, loaded on the edge that enters ACK; sim_end on the commit edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            data_out_r      <= 8'h00;
            ready_r         <= 1'b0;
            bus_err_r       <= 1'b0;
            uart_tx_valid_r <= 1'b0;
            uart_tx_data_r  <= 8'h00;
            sim_end_r       <= 1'b0;
            parity_err_r    <= 1'b0;
        end else begin
            ready_r         <= ack_nx_s;
            bus_err_r       <= ack_nx_s & bus_err_s;
            uart_tx_valid_r <= ack_nx_s & cur_wr_s & (cur_addr_s == ADDR_MUX_DATA);
            if (ack_nx_s && !cur_wr_s) begin
                data_out_r <= rd_data_s;
            end
            if (ack_nx_s && cur_wr_s && (cur_addr_s == ADDR_MUX_DATA)) begin
                uart_tx_data_r <= cur_data_s & UART_DATA_MASK;
            end
            if (commit_s && (addr_r == ADDR_SIM_END) && (wdata_r == SIM_END_KEY)) begin
                sim_end_r <= 1'b1;
            end
            if (ack_nx_s && !cur_wr_s && ram_hit_s && par_bad_s) begin
                parity_err_r <= 1'b1;
            end
        end
    end

    assign bus.data_out   = data_out_r;
    assign bus.ready      = ready_r;
    assign bus.bus_err    = bus_err_r;
    assign uart_tx_valid  = uart_tx_valid_r;
    assign uart_tx_data   = uart_tx_data_r;
    assign sim_end        = sim_end_r;
    assign parity_err     = parity_err_r;

endmodule

// File: tb/tb_banked_memory.sv
// -----------------------------------------------------------------------------
// tb_banked_memory
// Two instances: u_dut0 with zero wait states, u_dut3 with three. Each
// transfer pushes its expected result onto a scoreboard queue; the entry is
// popped and compared when ready strobes. ROM images are preloaded with
// rom_byte(i) = i[7:0] ^ 8'ha5.
// -----------------------------------------------------------------------------
module tb_banked_memory;

    logic clk  = 1'b0;
    logic rst  = 1'b1;
    logic pinj = 1'b0;

    always #5 clk = ~clk;

    banked_memory_if bus0();
    banked_memory_if bus3();

    logic       uv0, uv3, se0, se3, pe0, pe3;
    logic [7:0] ud0, ud3;

    banked_memory #(.WAIT_STATES(0)) u_dut0 (
        .clock(clk), .reset(rst), .bus(bus0),
        .uart_tx_valid(uv0), .uart_tx_data(ud0), .sim_end(se0),
        .parity_inject(pinj), .parity_err(pe0)
    );

    banked_memory #(.WAIT_STATES(3)) u_dut3 (
        .clock(clk), .reset(rst), .bus(bus3),
        .uart_tx_valid(uv3), .uart_tx_data(ud3), .sim_end(se3),
        .parity_inject(pinj), .parity_err(pe3)
    );

`ifdef MEM_PARITY_EN
    localparam logic EXP_PAR = 1'b1;
`else
    localparam logic EXP_PAR = 1'b0;
`endif

    typedef struct {
        logic [7:0] data;
        logic       err;
        bit         chk_data;
    } exp_t;

    exp_t       sb_q[$];
    int         n_compared   = 0;
    int         n_mismatched = 0;
    logic       ack_uv;
    logic [7:0] ack_ud;

    task automatic check_value(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] rom_byte(input int i);
        return 8'(i) ^ 8'ha5;
    endfunction

    function automatic logic get_ready(input int which);
        return (which == 0) ? bus0.ready : bus3.ready;
    endfunction

    function automatic logic get_err(input int which);
        return (which == 0) ? bus0.bus_err : bus3.bus_err;
    endfunction

    function automatic logic [7:0] get_data(input int which);
        return (which == 0) ? bus0.data_out : bus3.data_out;
    endfunction

    task automatic drive(input int which, input logic [15:0] a, input logic rd, input logic wr,
                         input logic [7:0] d);
        if (which == 0) begin
            bus0.address = a; bus0.read_en = rd; bus0.write_en = wr; bus0.data_in = d;
        end else begin
            bus3.address = a; bus3.read_en = rd; bus3.write_en = wr; bus3.data_in = d;
        end
    endtask

    // One complete bus transfer, checked against the scoreboard entry it pushes.
    task automatic xfer(input string tag, input int which, input logic [15:0] a, input logic rd,
                        input logic wr, input logic [7:0] d, input logic [7:0] exp_d,
                        input logic exp_err);
        exp_t e;
        int   n    = 0;
        bit   seen = 1'b0;
        int   lat  = (which == 0) ? 1 : 4;
        sb_q.push_back('{data: exp_d, err: exp_err, chk_data: (rd && !wr)});
        drive(which, a, rd, wr, d);
        while (!seen && n < 32) begin
            @(posedge clk); #1;
            n++;
            if (get_ready(which)) begin
                seen   = 1'b1;
                ack_uv = (which == 0) ? uv0 : uv3;
                ack_ud = (which == 0) ? ud0 : ud3;
                e      = sb_q.pop_front();
                check_value({tag, "_lat"}, 16'(n), 16'(lat));
                if (e.chk_data) begin
                    check_value({tag, "_data"}, {8'h00, get_data(which)}, {8'h00, e.data});
                end
                check_value({tag, "_err"}, 16'(get_err(which)), 16'(e.err));
            end
        end
        check_value({tag, "_seen"}, 16'(seen), 16'd1);
        if (!seen) begin
            e = sb_q.pop_front();
        end
        drive(which, 16'h0000, 1'b0, 1'b0, 8'h00);
        @(posedge clk); #1;
        check_value({tag, "_rdy_1cyc"}, 16'(get_ready(which)), 16'd0);
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) begin
            u_dut0.u_rom.mem_r[i] = rom_byte(i);
            u_dut3.u_rom.mem_r[i] = rom_byte(i);
        end
        drive(0, 16'h0000, 1'b0, 1'b0, 8'h00);
        drive(1, 16'h0000, 1'b0, 1'b0, 8'h00);
        repeat (2) @(posedge clk);
        #1;
        check_value("rst_data",  {8'h00, bus3.data_out}, 16'h0000);
        check_value("rst_ready", 16'(bus3.ready), 16'd0);
        check_value("rst_err",   16'(bus3.bus_err), 16'd0);
        check_value("rst_uv",    16'(uv3), 16'd0);
        check_value("rst_ud",    {8'h00, ud3}, 16'h0000);
        check_value("rst_se",    16'(se0), 16'd0);
        check_value("rst_pe",    16'(pe3), 16'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Zero-wait instance: vector, registers, map boundaries.
        xfer("vec0", 0, 16'hfd00, 1'b1, 1'b0, 8'h00, 8'h71, 1'b0);
        xfer("vec1", 0, 16'hfd01, 1'b1, 1'b0, 8'h00, 8'h80, 1'b0);
        xfer("vec2", 0, 16'hfd02, 1'b1, 1'b0, 8'h00, 8'h01, 1'b0);
        xfer("uart", 0, 16'hf201, 1'b0, 1'b1, 8'hc8, 8'h00, 1'b0);
        check_value("uart_valid", 16'(ack_uv), 16'd1);
        check_value("uart_data",  {8'h00, ack_ud}, 16'h0048);
        check_value("uart_pulse", 16'(uv0), 16'd0);
        check_value("data_hold",  {8'h00, bus0.data_out}, 16'h0001);
        xfer("stat",   0, 16'hf200, 1'b1, 1'b0, 8'h00, 8'h02, 1'b0);
        xfer("dip",    0, 16'hf110, 1'b1, 1'b0, 8'h00, 8'h0d, 1'b0);
        xfer("unmap",  0, 16'h1234, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
        xfer("simx",   0, 16'hf900, 1'b0, 1'b1, 8'h02, 8'h00, 1'b0);
        check_value("sim_end_02", 16'(se0), 16'd0);
        xfer("sim1",   0, 16'hf900, 1'b0, 1'b1, 8'h01, 8'h00, 1'b0);
        check_value("sim_end_01", 16'(se0), 16'd1);
        xfer("after",  0, 16'hf200, 1'b1, 1'b0, 8'h00, 8'h02, 1'b0);
        check_value("sim_end_sticky", 16'(se0), 16'd1);
        xfer("romwr",  0, 16'h8010, 1'b0, 1'b1, 8'hff, 8'h00, 1'b1);
        xfer("romrd",  0, 16'h8010, 1'b1, 1'b0, 8'h00, rom_byte(16), 1'b0);
        xfer("romtop", 0, 16'h87ff, 1'b1, 1'b0, 8'h00, rom_byte(2047), 1'b0);
        xfer("vecwr",  0, 16'hfd01, 1'b0, 1'b1, 8'h00, 8'h00, 1'b1);
        xfer("vecrd",  0, 16'hfd01, 1'b1, 1'b0, 8'h00, 8'h80, 1'b0);
        xfer("both",   0, 16'hb800, 1'b1, 1'b1, 8'h77, 8'h00, 1'b1);
        xfer("bothrd", 0, 16'hb800, 1'b1, 1'b0, 8'h00, 8'h77, 1'b0);

        // Three-wait instance: RAM, window boundary, parity.
        xfer("ramwr",  1, 16'hb805, 1'b0, 1'b1, 8'h5a, 8'h00, 1'b0);
        xfer("ramrd",  1, 16'hb805, 1'b1, 1'b0, 8'h00, 8'h5a, 1'b0);
        xfer("alias",  1, 16'hc005, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
        check_value("par_clean", 16'(pe3), 16'd0);
        pinj = 1'b1;
        xfer("parwr",  1, 16'hb820, 1'b0, 1'b1, 8'h3c, 8'h00, 1'b0);
        pinj = 1'b0;
        xfer("parrd",  1, 16'hb820, 1'b1, 1'b0, 8'h00, 8'h3c, 1'b0);
        check_value("par_err", 16'(pe3), 16'(EXP_PAR));
        xfer("parrd2", 1, 16'hb805, 1'b1, 1'b0, 8'h00, 8'h5a, 1'b0);
        check_value("par_sticky", 16'(pe3), 16'(EXP_PAR));

        // Reset in the middle of a waited write abandons it.
        xfer("prewr",  1, 16'hb810, 1'b0, 1'b1, 8'h00, 8'h00, 1'b0);
        drive(1, 16'hb810, 1'b0, 1'b1, 8'h11);
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            check_value("midwait_rdy", 16'(bus3.ready), 16'd0);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        check_value("inrst_rdy", 16'(bus3.ready), 16'd0);
        drive(1, 16'h0000, 1'b0, 1'b0, 8'h00);
        rst = 1'b0;
        @(posedge clk); #1;
        check_value("postrst_rdy", 16'(bus3.ready), 16'd0);
        check_value("postrst_pe",  16'(pe3), 16'd0);
        check_value("postrst_se",  16'(se0), 16'd0);
        check_value("postrst_data", {8'h00, bus3.data_out}, 16'h0000);
        xfer("abandon", 1, 16'hb810, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
        check_value("sb_empty", 16'(sb_q.size()), 16'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
